// File: rtl/datapath_param.sv
//==============================================================================
// Module  : datapath_param
// Brief   : Parametrised SAP-style datapath: A/B/OUT/IR/MAR/PC registers, 4-op
//           ALU with registered flags, async-read RAM and encoded bus mux.
//           Optional signed-overflow flag VF when DATAPATH_PARAM_VF_EN is defined.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module datapath_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              CLR,
    input  logic [2:0]        BUS_SEL,
    input  logic              LD_A,
    input  logic              LD_B,
    input  logic              LD_O,
    input  logic              LD_I,
    input  logic              LD_M,
    input  logic              LD_R,
    input  logic              CE,
    input  logic              JMP,
    input  logic [1:0]        COND,
    input  logic [1:0]        ALU_OP,
    input  logic              FIn,
    input  logic [DATA_W-1:0] DEBUG,
    input  logic [DATA_W-1:0] INREG,
    output logic [DATA_W-1:0] BUS,
    output logic [3:0]        OPCODE,
    output logic              CF,
    output logic              ZF,
    output logic              NF,
`ifdef DATAPATH_PARAM_VF_EN
    output logic              VF,
`endif
    output logic [DATA_W-1:0] OUTREG,
    output logic [ADDR_W-1:0] PC_OUT
);

    localparam int          c_DEPTH = 2 ** ADDR_W;
    localparam logic [2:0]  c_SEL_DEBUG = 3'd0;
    localparam logic [2:0]  c_SEL_A     = 3'd1;
    localparam logic [2:0]  c_SEL_B     = 3'd2;
    localparam logic [2:0]  c_SEL_IR    = 3'd3;
    localparam logic [2:0]  c_SEL_PC    = 3'd4;
    localparam logic [2:0]  c_SEL_ALU   = 3'd5;
    localparam logic [2:0]  c_SEL_RAM   = 3'd6;

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_out;
    logic [DATA_W-1:0] r_ir;
    logic [ADDR_W-1:0] r_mar;
    logic [ADDR_W-1:0] r_pc;
    logic              r_cf;
    logic              r_zf;
    logic              r_nf;
    logic [DATA_W-1:0] r_ram [c_DEPTH];

    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_alu_r;
    logic              w_alu_c;
    logic [DATA_W-1:0] w_ram_rd;
    logic              w_cond_ok;
    logic [DATA_W-1:0] w_bus;

    assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff   = {1'b0, r_a} + {1'b0, ~r_b} + {{DATA_W{1'b0}}, 1'b1};
    assign w_ram_rd = r_ram[r_mar];

    always_comb begin
        w_alu_r = '0;
        w_alu_c = 1'b0;
        case (ALU_OP)
            2'b00:   {w_alu_c, w_alu_r} = w_sum;
            2'b01:   {w_alu_c, w_alu_r} = w_diff;
            2'b10:   w_alu_r = r_a & r_b;
            default: w_alu_r = r_a ^ r_b;
        endcase
    end

    always_comb begin
        w_bus = '0;
        case (BUS_SEL)
            c_SEL_DEBUG: w_bus = DEBUG;
            c_SEL_A:     w_bus = r_a;
            c_SEL_B:     w_bus = r_b;
            c_SEL_IR:    w_bus = {{(DATA_W-ADDR_W){1'b0}}, r_ir[ADDR_W-1:0]};
            c_SEL_PC:    w_bus = {{(DATA_W-ADDR_W){1'b0}}, r_pc};
            c_SEL_ALU:   w_bus = w_alu_r;
            c_SEL_RAM:   w_bus = w_ram_rd;
            default:     w_bus = INREG;
        endcase
    end

    // Condition is evaluated on the pre-edge flags, so a same-cycle FIn has no effect on it
    always_comb begin
        w_cond_ok = 1'b0;
        case (COND)
            2'b00:   w_cond_ok = 1'b1;
            2'b01:   w_cond_ok = r_cf;
            2'b10:   w_cond_ok = r_zf;
            default: w_cond_ok = r_nf;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn || CLR) begin
            r_a   <= '0;
            r_b   <= '0;
            r_out <= '0;
            r_ir  <= '0;
            r_mar <= '0;
            r_pc  <= '0;
            r_cf  <= 1'b0;
            r_zf  <= 1'b0;
            r_nf  <= 1'b0;
        end else begin
            if (LD_A) r_a   <= w_bus;
            if (LD_B) r_b   <= w_bus;
            if (LD_O) r_out <= w_bus;
            if (LD_I) r_ir  <= w_bus;
            if (LD_M) r_mar <= w_bus[ADDR_W-1:0];
            if (JMP && w_cond_ok) r_pc <= w_bus[ADDR_W-1:0];
            else if (CE)          r_pc <= r_pc + 1'b1;
            if (FIn) begin
                r_cf <= w_alu_c;
                r_zf <= (w_alu_r == '0);
                r_nf <= w_alu_r[DATA_W-1];
            end
        end
    end

    // RAM keeps its contents across reset/clear; write address is the pre-edge MAR
    always_ff @(posedge CLK) begin
        if (RESETn && !CLR && LD_R) r_ram[r_mar] <= w_bus;
    end

`ifdef DATAPATH_PARAM_VF_EN
    logic r_vf;
    logic w_alu_v;

    always_comb begin
        w_alu_v = 1'b0;
        case (ALU_OP)
            2'b00:   w_alu_v = (r_a[DATA_W-1] == r_b[DATA_W-1]) &&
                               (w_sum[DATA_W-1] != r_a[DATA_W-1]);
            2'b01:   w_alu_v = (r_a[DATA_W-1] != r_b[DATA_W-1]) &&
                               (w_diff[DATA_W-1] != r_a[DATA_W-1]);
            default: w_alu_v = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn || CLR) r_vf <= 1'b0;
        else if (FIn)       r_vf <= w_alu_v;
    end

    assign VF = r_vf;
`endif

    assign BUS    = w_bus;
    assign OPCODE = r_ir[DATA_W-1:DATA_W-4];
    assign CF     = r_cf;
    assign ZF     = r_zf;
    assign NF     = r_nf;
    assign OUTREG = r_out;
    assign PC_OUT = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_datapath_param.sv
//==============================================================================
// Module  : tb_datapath_param
// Brief   : Directed self-checking bench for datapath_param (8/4 and 12/6 builds).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_datapath_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance 0: DATA_W=8, ADDR_W=4
    logic       rstn, clr, ld_a, ld_b, ld_o, ld_i, ld_m, ld_r, ce, jmp, fin;
    logic [2:0] sel;
    logic [1:0] cond, op;
    logic [7:0] dbg, inreg;
    logic [7:0] bus, outreg;
    logic [3:0] opc, pc;
    logic       cf, zf, nf;

    datapath_param #(.DATA_W(8), .ADDR_W(4)) u0 (
        .CLK(clk), .RESETn(rstn), .CLR(clr), .BUS_SEL(sel),
        .LD_A(ld_a), .LD_B(ld_b), .LD_O(ld_o), .LD_I(ld_i), .LD_M(ld_m), .LD_R(ld_r),
        .CE(ce), .JMP(jmp), .COND(cond), .ALU_OP(op), .FIn(fin),
        .DEBUG(dbg), .INREG(inreg), .BUS(bus), .OPCODE(opc),
        .CF(cf), .ZF(zf), .NF(nf), .OUTREG(outreg), .PC_OUT(pc)
    );

    // Instance 1: DATA_W=12, ADDR_W=6
    logic        p_rstn, p_clr, p_ld_a, p_ld_b, p_ld_o, p_ld_i, p_ld_m, p_ld_r;
    logic        p_ce, p_jmp, p_fin;
    logic [2:0]  p_sel;
    logic [1:0]  p_cond, p_op;
    logic [11:0] p_dbg, p_inreg, p_bus, p_outreg;
    logic [3:0]  p_opc;
    logic [5:0]  p_pc;
    logic        p_cf, p_zf, p_nf;

    datapath_param #(.DATA_W(12), .ADDR_W(6)) u1 (
        .CLK(clk), .RESETn(p_rstn), .CLR(p_clr), .BUS_SEL(p_sel),
        .LD_A(p_ld_a), .LD_B(p_ld_b), .LD_O(p_ld_o), .LD_I(p_ld_i), .LD_M(p_ld_m),
        .LD_R(p_ld_r), .CE(p_ce), .JMP(p_jmp), .COND(p_cond), .ALU_OP(p_op),
        .FIn(p_fin), .DEBUG(p_dbg), .INREG(p_inreg), .BUS(p_bus), .OPCODE(p_opc),
        .CF(p_cf), .ZF(p_zf), .NF(p_nf), .OUTREG(p_outreg), .PC_OUT(p_pc)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle;
        clr = 0; ld_a = 0; ld_b = 0; ld_o = 0; ld_i = 0; ld_m = 0; ld_r = 0;
        ce = 0; jmp = 0; fin = 0; cond = 2'b00;
    endtask

    task automatic p_idle;
        p_clr = 0; p_ld_a = 0; p_ld_b = 0; p_ld_o = 0; p_ld_i = 0; p_ld_m = 0;
        p_ld_r = 0; p_ce = 0; p_jmp = 0; p_fin = 0; p_cond = 2'b00;
    endtask

    // Load A and B through the DEBUG source
    task automatic ldab(input logic [7:0] a, input logic [7:0] b);
        idle(); sel = 3'd0; dbg = a; ld_a = 1; step();
        idle(); dbg = b; ld_b = 1; step();
        idle();
    endtask

    // Make every register nonzero: A=B=OUT=IR=0xC7, MAR=7, PC=1, CF=NF=1
    task automatic dirty;
        idle(); sel = 3'd0; dbg = 8'hC7;
        ld_a = 1; ld_b = 1; ld_o = 1; ld_i = 1; ld_m = 1; ce = 1; step();
        idle(); op = 2'b00; fin = 1; step();
        idle();
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_out"}, outreg, 0);
        chk({pfx, "_pc"}, pc, 0);
        chk({pfx, "_flags"}, {cf, zf, nf}, 0);
        chk({pfx, "_opc"}, opc, 0);
        sel = 3'd1; #1 chk({pfx, "_a"}, bus, 0);
        sel = 3'd2; #1 chk({pfx, "_b"}, bus, 0);
        sel = 3'd3; #1 chk({pfx, "_ir"}, bus, 0);
    endtask

    initial begin
        idle(); p_idle();
        rstn = 0; sel = 0; op = 0; dbg = 0; inreg = 0;
        p_rstn = 0; p_sel = 0; p_op = 0; p_dbg = 0; p_inreg = 0;
        step();
        rstn = 1;
        check_zero("rst0");

        // RAM[3] = 0x5A
        idle(); sel = 3'd0; dbg = 8'h03; ld_m = 1; step();
        idle(); dbg = 8'h5A; ld_r = 1; step();

        dirty();
        chk("dirty_out", outreg, 8'hC7);
        chk("dirty_pc", pc, 1);
        chk("dirty_flags", {cf, zf, nf}, 3'b101);

        // Reset wins over CLR and loads
        rstn = 0; clr = 1; sel = 3'd0; dbg = 8'hFF; ld_a = 1; ld_o = 1; ce = 1; fin = 1;
        step();
        rstn = 1; idle();
        check_zero("rst1");

        dirty();
        clr = 1; sel = 3'd0; dbg = 8'hFF; ld_a = 1; ld_o = 1; ld_i = 1; ce = 1; fin = 1;
        jmp = 1; step();
        idle();
        check_zero("clr");
        sel = 3'd0; dbg = 8'h03; ld_m = 1; step();
        idle(); sel = 3'd6; #1 chk("ram_keep", bus, 8'h5A);

        // Transfers
        inreg = 8'h3C; sel = 3'd7; ld_a = 1; step();
        idle(); sel = 3'd1; #1 chk("xfer_a", bus, 8'h3C);
        ld_b = 1; ld_o = 1; step();
        idle(); chk("xfer_out", outreg, 8'h3C);
        sel = 3'd2; #1 chk("xfer_b", bus, 8'h3C);

        // ALU and flags
        ldab(8'h05, 8'h05); op = 2'b01; sel = 3'd5; #1 chk("sub_eq_r", bus, 8'h00);
        fin = 1; step(); idle();
        chk("sub_eq_flags", {cf, zf, nf}, 3'b110);

        ldab(8'hF0, 8'h20); op = 2'b00; sel = 3'd5; #1 chk("add_c_r", bus, 8'h10);
        fin = 1; step(); idle();
        chk("add_c_flags", {cf, zf, nf}, 3'b100);

        ldab(8'h03, 8'h05); op = 2'b01; sel = 3'd5; #1 chk("sub_b_r", bus, 8'hFE);
        fin = 1; step(); idle();
        chk("sub_b_flags", {cf, zf, nf}, 3'b001);

        ldab(8'hF0, 8'h3C); op = 2'b10; sel = 3'd5; #1 chk("and_r", bus, 8'h30);
        op = 2'b11; #1 chk("xor_r", bus, 8'hCC);
        fin = 1; step(); idle();
        chk("xor_flags", {cf, zf, nf}, 3'b001);

        // Memory
        sel = 3'd0; dbg = 8'h08; ld_m = 1; step();
        idle(); dbg = 8'h11; ld_r = 1; step();
        idle(); dbg = 8'h07; ld_m = 1; step();
        idle(); dbg = 8'hA5; ld_r = 1; step();
        idle(); sel = 3'd6; #1 chk("ram_rd7", bus, 8'hA5);
        sel = 3'd0; dbg = 8'h08; ld_m = 1; ld_r = 1; step();
        idle(); sel = 3'd6; #1 chk("ram_rd8_kept", bus, 8'h11);
        sel = 3'd0; dbg = 8'h07; ld_m = 1; step();
        idle(); sel = 3'd6; #1 chk("ram_old_mar", bus, 8'h08);
        ld_r = 1; step();
        idle(); #1 chk("ram_rewrite", bus, 8'h08);

        // PC
        sel = 3'd0; dbg = 8'h0F; jmp = 1; cond = 2'b00; step();
        idle(); chk("pc_jmp15", pc, 15);
        ce = 1; step(); idle();
        chk("pc_wrap", pc, 0);
        ldab(8'h05, 8'h05); op = 2'b01; fin = 1; step(); idle();
        sel = 3'd0; dbg = 8'h09; jmp = 1; cond = 2'b10; ce = 1; step();
        idle(); chk("pc_jz_taken", pc, 9);
        ldab(8'h03, 8'h05); op = 2'b01; fin = 1; step(); idle();
        sel = 3'd0; dbg = 8'h02; jmp = 1; cond = 2'b10; ce = 1; step();
        idle(); chk("pc_jz_not", pc, 10);
        sel = 3'd0; dbg = 8'h02; jmp = 1; cond = 2'b11; step();
        idle(); chk("pc_jn", pc, 2);
        sel = 3'd0; dbg = 8'h06; jmp = 1; cond = 2'b01; step();
        idle(); chk("pc_jc_hold", pc, 2);
        ldab(8'h05, 8'h05); op = 2'b01;
        sel = 3'd0; dbg = 8'h04; jmp = 1; cond = 2'b10; fin = 1; step();
        idle(); chk("pc_old_flags", pc, 2);
        chk("pc_old_flags_zf", zf, 1);
        sel = 3'd0; dbg = 8'h04; jmp = 1; cond = 2'b10; step();
        idle(); chk("pc_new_flags", pc, 4);

        // Wide build: DATA_W=12, ADDR_W=6
        p_rstn = 1; p_sel = 3'd0;
        p_dbg = 12'h03F; p_jmp = 1; step();
        p_idle(); chk("w_pc63", p_pc, 63);
        p_ce = 1; step(); p_idle();
        chk("w_pc_wrap", p_pc, 0);
        p_dbg = 12'hA55; p_ld_i = 1; step(); p_idle();
        chk("w_opcode", p_opc, 4'hA);
        p_sel = 3'd3; #1 chk("w_ir_opnd", p_bus, 12'h015);
        p_sel = 3'd0; p_dbg = 12'hFFF; p_ld_a = 1; step(); p_idle();
        p_dbg = 12'h001; p_ld_b = 1; step(); p_idle();
        p_op = 2'b00; p_sel = 3'd5; #1 chk("w_add_r", p_bus, 12'h000);
        p_fin = 1; step(); p_idle();
        chk("w_add_flags", {p_cf, p_zf, p_nf}, 3'b110);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/datapath_param.md
Name: datapath_param

Overview:
Parametrised next-generation datapath for the SAP-style CPU: a data width of DATA_W bits and an address space of 2^ADDR_W words.
- Contains A, B, OUT and IR registers, a memory address register (MAR), program counter, a 4-op ALU with registered flags, internal RAM, and an encoded bus source mux.
- Adds conditional jump, a negative flag and an ALU op select.
- The control FSM sits above it and drives one bus source plus any set of load strobes per cycle.

Parameters:
DATA_W, 8, bus/register/RAM word width; must be >= ADDR_W+4
ADDR_W, 4, PC/MAR width; RAM depth = 2^ADDR_W

Ports:
CLK  in  1  clock; all state updates on rising edge
RESETn  in  1  synchronous active-low reset
CLR  in  1  synchronous clear of all registers and flags (RAM untouched)
BUS_SEL  in  3  bus source: 0 DEBUG, 1 A, 2 B, 3 IR operand, 4 PC, 5 ALU, 6 RAM, 7 INREG
LD_A, LD_B, LD_O, LD_I, LD_M  in  1 each  load A/B/OUT/IR/MAR from BUS
LD_R  in  1  write BUS into RAM[MAR]
CE  in  1  PC increment
JMP  in  1  jump request; PC <= BUS[ADDR_W-1:0] if condition true
COND  in  2  jump condition: 00 always, 01 CF, 10 ZF, 11 NF
ALU_OP  in  2  00 ADD, 01 SUB, 10 AND, 11 XOR
FIn  in  1  load flags from current ALU result
DEBUG  in  DATA_W  debug bus source
INREG  in  DATA_W  input port
BUS  out  DATA_W  current bus value (combinational)
OPCODE  out  4  IR[DATA_W-1:DATA_W-4]
CF, ZF, NF  out  1 each  registered flags
OUTREG  out  DATA_W  output register
PC_OUT  out  ADDR_W  program counter (debug)

Behaviour:
- Reset:
  - RESETn=0 at an edge -> A, B, OUT, IR, MAR, PC, CF, ZF, NF all 0.
  - RESETn takes priority over CLR, which takes priority over all loads, CE and JMP.
- RAM is not cleared by reset or CLR. Contents are undefined until written.
- BUS is purely combinational from BUS_SEL and the source values. The IR operand source is IR[ADDR_W-1:0] zero-extended. The PC source is PC zero-extended.
- Loads sample BUS at the edge, so a register-to-register transfer takes 1 cycle. Multiple LD_* may be active together.
- LD_M loads MAR <= BUS[ADDR_W-1:0]. The RAM read is asynchronous: RAM[MAR].
- RAM write with LD_R and LD_M in the same cycle: the write uses the old MAR.
- BUS_SEL=6 with LD_R: the same word is rewritten.
- ALU (combinational from A and B):
  - ADD: {c,r} = A+B.
  - SUB: {c,r} = A + ~B + 1, so CF=1 means no borrow.
  - AND/XOR: c=0.
- Flags: on FIn, CF<=c, ZF<=(r==0), NF<=r[DATA_W-1]. Otherwise the flags hold.
- PC:
  - JMP with a true condition -> PC <= BUS[ADDR_W-1:0]. This overrides CE in the same cycle.
  - JMP with a false condition and CE=1 -> increment.
  - CE alone -> PC+1, wrapping 2^ADDR_W-1 -> 0.
- The jump condition uses the flag values before the edge, even if FIn is asserted in the same cycle.
- No internal FSM; latency of every load is 1 cycle.

Optional Feature:
DATAPATH_PARAM_VF_EN
- Defined: adds output VF (1 bit), the signed-overflow flag, loaded on FIn.
  - ADD: VF = (A[msb]==B[msb]) && (r[msb]!=A[msb]).
  - SUB: VF = (A[msb]!=B[msb]) && (r[msb]!=A[msb]).
  - AND/XOR: VF = 0.
  - Reset/CLR -> 0.
  - COND encoding is unchanged.
- Undefined: no VF port and no VF flop.

Test Plan:
- Reset/clear: set all registers nonzero, pulse RESETn=0 one cycle -> every register, PC and flags read 0. Repeat with CLR=1 -> same result; RAM[3] previously written 0x5A still reads 0x5A.
- Transfer: INREG=0x3C, BUS_SEL=7, LD_A -> A=0x3C. Next cycle BUS_SEL=1, LD_B|LD_O -> B=OUTREG=0x3C.
- ALU/flags (DATA_W=8):
  - A=0x05, B=0x05, SUB, FIn -> CF=1, ZF=1, NF=0.
  - A=0xF0, B=0x20, ADD, FIn -> r=0x10, CF=1, ZF=0.
  - A=0x03, B=0x05, SUB -> r=0xFE, CF=0, NF=1.
- Memory: BUS=0x07, LD_M; then DEBUG=0xA5, BUS_SEL=0, LD_R; then BUS_SEL=6 -> BUS=0xA5. Simultaneous LD_M(0x08)+LD_R writes address 7, not 8.
- PC:
  - CE from PC=15 (ADDR_W=4) -> 0.
  - JMP COND=10 with ZF=1 and BUS=0x09, CE=1 -> PC=9.
  - ZF=0 with CE=1 -> PC+1.
  - JMP with FIn in the same cycle uses the old flags.
- Parameter sweep: DATA_W=12, ADDR_W=6 -> PC wraps at 63, OPCODE=IR[11:8], ADD 0xFFF+0x001 -> r=0, CF=1, ZF=1.
